// File: rtl/mips_exec_mem_if.sv
// Operand, control and data-memory signals of the execute/memory stage.
// The master side drives the instruction fields and operands; the stage is the slave.
interface mips_exec_mem_if;
   logic [5:0]  opcode;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [31:0] in1;
   logic [31:0] in2;
   logic [31:0] wdata;
   logic [31:0] address;
   logic [31:0] result;
   logic        zero;
   logic        rw;
   logic [31:0] out;

   modport master (
      output opcode, shamt, funct, in1, in2, wdata, address,
      input  result, zero, rw, out
   );

   modport slave (
      input  opcode, shamt, funct, in1, in2, wdata, address,
      output result, zero, rw, out
   );
endinterface

// File: rtl/mips_exec_mem.sv
// Single-cycle MIPS execute/memory stage: combinational ALU plus a word-addressed
// data memory with asynchronous read, clocked write and asynchronous clear.
module mips_exec_mem #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input logic             clk,
   input logic             rst_n,
   mips_exec_mem_if.slave  bus
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLL = 6'b000000;
   localparam logic [5:0] FN_SRL = 6'b000010;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [31:0]   alu_res;
   logic          rw_dec;
   logic          unused_addr;

   always_comb begin
      alu_res = '0;
      rw_dec  = 1'b0;
      unique case (bus.opcode)
         OP_RTYPE: begin
            rw_dec = 1'b1;
            case (bus.funct)
               FN_ADD:  alu_res = bus.in1 + bus.in2;
               FN_SUB:  alu_res = bus.in1 - bus.in2;
               FN_AND:  alu_res = bus.in1 & bus.in2;
               FN_OR:   alu_res = bus.in1 | bus.in2;
               FN_SLL:  alu_res = bus.in2 << bus.shamt;
               FN_SRL:  alu_res = bus.in2 >> bus.shamt;
               default: rw_dec  = 1'b0;
            endcase
         end
         OP_LW: begin
            alu_res = bus.in1 + bus.in2;
            rw_dec  = 1'b1;
         end
         OP_SW:   alu_res = bus.in1 + bus.in2;
         OP_BEQ:  alu_res = bus.in1 - bus.in2;
         default: alu_res = '0;
      endcase
   end

   assign bus.result = alu_res;
   assign bus.zero   = (alu_res == '0);
   assign bus.rw     = rw_dec & rst_n;

   // Byte offset and bits above the memory span are dropped, so addresses wrap.
   assign idx         = bus.address[AW+1:2];
   assign unused_addr = ^{bus.address[31:AW+2], bus.address[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (bus.opcode == OP_SW) begin
         mem[idx] <= bus.wdata;
      end
   end

   assign bus.out = mem[idx];

endmodule

// File: tb/tb_mips_exec_mem.sv
// Directed bench for mips_exec_mem: ALU ops, store/load timing, address wrap, reset clear.
module tb_mips_exec_mem;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   mips_exec_mem_if bus ();

   mips_exec_mem #(
      .DEPTH (64),
      .AW    (6)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] wd, input logic [31:0] ad);
      bus.opcode  = op;
      bus.funct   = fn;
      bus.shamt   = sh;
      bus.in1     = a;
      bus.in2     = b;
      bus.wdata   = wd;
      bus.address = ad;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      drive(6'b111111, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      #1;
      check("reset_out", bus.out, 32'h0);
      check("reset_result", bus.result, 32'h0);
      check("reset_zero", {31'd0, bus.zero}, 32'd1);
      drive(6'b000000, 6'b100000, 5'd0, 32'd1, 32'd2, 32'd0, 32'd0);
      #1;
      check("reset_rw_forced", {31'd0, bus.rw}, 32'd0);
      check("reset_add_result", bus.result, 32'd3);

      @(negedge clk);
      rst_n = 1'b1;

      // ALU
      drive(6'b000000, 6'b100000, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
      #1;
      check("add_wrap_result", bus.result, 32'h0);
      check("add_wrap_zero", {31'd0, bus.zero}, 32'd1);
      check("add_rw", {31'd0, bus.rw}, 32'd1);
      drive(6'b000000, 6'b100010, 5'd0, 32'd0, 32'd1, 32'd0, 32'd0);
      #1;
      check("sub_wrap_result", bus.result, 32'hFFFF_FFFF);
      check("sub_wrap_zero", {31'd0, bus.zero}, 32'd0);
      drive(6'b000000, 6'b100100, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0);
      #1;
      check("and_result", bus.result, 32'hF000_F000);
      drive(6'b000000, 6'b100101, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'd0, 32'd0);
      #1;
      check("or_result", bus.result, 32'hFFF0_FFF0);
      drive(6'b000000, 6'b000000, 5'd31, 32'd0, 32'd1, 32'd0, 32'd0);
      #1;
      check("sll_result", bus.result, 32'h8000_0000);
      check("sll_rw", {31'd0, bus.rw}, 32'd1);
      drive(6'b000000, 6'b000010, 5'd31, 32'd0, 32'h8000_0000, 32'd0, 32'd0);
      #1;
      check("srl_result", bus.result, 32'd1);
      drive(6'b000000, 6'b100111, 5'd0, 32'd5, 32'd6, 32'd0, 32'd0);
      #1;
      check("bad_funct_result", bus.result, 32'h0);
      check("bad_funct_rw", {31'd0, bus.rw}, 32'd0);

      // Store then load: old data before the edge, new data after
      @(negedge clk);
      drive(6'b101011, 6'd0, 5'd0, 32'd4, 32'd4, 32'hDEAD_BEEF, 32'd8);
      #1;
      check("sw_result", bus.result, 32'd8);
      check("sw_rw", {31'd0, bus.rw}, 32'd0);
      check("sw_out_before_edge", bus.out, 32'h0);
      @(posedge clk);
      #1;
      check("sw_out_after_edge", bus.out, 32'hDEAD_BEEF);
      drive(6'b100011, 6'd0, 5'd0, 32'd4, 32'd4, 32'd0, 32'd8);
      #1;
      check("lw_result", bus.result, 32'd8);
      check("lw_rw", {31'd0, bus.rw}, 32'd1);
      check("lw_out", bus.out, 32'hDEAD_BEEF);

      // Address wrap and byte-offset masking
      @(negedge clk);
      drive(6'b101011, 6'd0, 5'd0, 32'd0, 32'h100, 32'h1234_5678, 32'h100);
      #1;
      check("wrap_out_before_edge", bus.out, 32'h0);
      @(posedge clk);
      #1;
      drive(6'b111111, 6'd0, 5'd0, 32'd0, 32'd0, 32'hCAFE_F00D, 32'd3);
      #1;
      check("wrap_word0_via_addr3", bus.out, 32'h1234_5678);
      check("illegal_result", bus.result, 32'h0);
      check("illegal_rw", {31'd0, bus.rw}, 32'd0);
      @(posedge clk);
      #1;
      check("illegal_no_write", bus.out, 32'h1234_5678);
      bus.address = 32'd8;
      #1;
      check("illegal_word2_kept", bus.out, 32'hDEAD_BEEF);

      // BEQ
      drive(6'b000100, 6'd0, 5'd0, 32'd7, 32'd7, 32'd0, 32'd0);
      #1;
      check("beq_eq_zero", {31'd0, bus.zero}, 32'd1);
      check("beq_rw", {31'd0, bus.rw}, 32'd0);
      drive(6'b000100, 6'd0, 5'd0, 32'd7, 32'd9, 32'd0, 32'd0);
      #1;
      check("beq_ne_result", bus.result, 32'hFFFF_FFFE);
      check("beq_ne_zero", {31'd0, bus.zero}, 32'd0);

      // Fill word 5, then reset asynchronously between edges
      @(negedge clk);
      drive(6'b101011, 6'd0, 5'd0, 32'd0, 32'd20, 32'hA5A5_A5A5, 32'd20);
      @(posedge clk);
      #1;
      drive(6'b111111, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd20);
      #1;
      check("word5_filled", bus.out, 32'hA5A5_A5A5);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_clears_word5", bus.out, 32'h0);
      bus.address = 32'd0;
      #1;
      check("reset_clears_word0", bus.out, 32'h0);
      drive(6'b101011, 6'd0, 5'd0, 32'd0, 32'd20, 32'h1111_1111, 32'd20);
      @(posedge clk);
      #1;
      check("sw_blocked_in_reset", bus.out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("out_after_release", bus.out, 32'h0);
      @(posedge clk);
      #1;
      check("sw_after_release", bus.out, 32'h1111_1111);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mips_exec_mem.md
# mips_exec_mem

Single-cycle execute/memory stage of the soft MIPS processor: a combinational 32-bit ALU decoding R-type funct codes and the LW/SW/BEQ opcodes, plus a word-addressed data memory with asynchronous read and clocked write. It sits between the register file and the write-back mux. The ALU result doubles as the data-memory address, and the read data returns in the same cycle for LW write-back. The clock is supplied externally; no clock generator lives in this block.

## Interface
- DEPTH, 64, number of 32-bit data-memory words (power of two)
- AW, 6, word-index width, log2(DEPTH)
- clk  input  1  rising-edge clock, used for memory writes only
- rst_n  input  1  asynchronous, active-low reset
- opcode  input  6  instruction opcode field
- shamt  input  5  shift amount field
- funct  input  6  R-type function field
- in1  input  32  operand A (Rs)
- in2  input  32  operand B (Rt or sign-extended immediate)
- wdata  input  32  store data (Rt)
- address  input  32  data-memory byte address (driven from result by the parent)
- result  output  32  ALU result
- zero  output  1  high when result == 0
- rw  output  1  register-file write enable
- out  output  32  data-memory read data

## Operation
- opcode 000000 (R-type), decoded by funct:
  - 100000 ADD: result = in1 + in2, modulo 2^32, no overflow trap.
  - 100010 SUB: result = in1 - in2, modulo 2^32.
  - 100100 AND: result = in1 & in2.
  - 100101 OR: result = in1 | in2.
  - 000000 SLL: result = in2 << shamt, zero fill.
  - 000010 SRL: result = in2 >> shamt, logical, zero fill.
  - rw = 1 for all six.
- opcode 100011 LW: result = in1 + in2; rw = 1.
- opcode 101011 SW: result = in1 + in2; rw = 0.
- opcode 000100 BEQ: result = in1 - in2; rw = 0; zero indicates branch taken.
- Any other opcode, or unlisted funct under 000000: result = 0, rw = 0, no memory write.
- Memory index = address[AW+1:2].
  - address[1:0] ignored; no misalignment fault.
  - Upper bits above AW+1 ignored, so addresses wrap modulo DEPTH words.
- Read: out = mem[index] combinationally, for every opcode.
- Write: mem[index] <= wdata on the rising clk edge when opcode == 101011 and rst_n == 1.
- Reset (rst_n low):
  - All memory words clear to 0 immediately, asynchronously; out reads 0.
  - rw forced to 0.
  - No write occurs while rst_n is low, including an SW present at the releasing edge if rst_n is still low at that edge.

## Timing
- result, zero, rw: purely combinational from opcode/funct/shamt/in1/in2, with zero cycles of latency.
- out: combinational from address and current memory contents, with zero latency.
- A store takes effect at the clk edge. A read of the same index in the same cycle returns the old data; the new data appears after the edge. There is no write-through bypass.
- Write-then-read to the same word on consecutive cycles returns the written value in the second cycle.
- Reset asserted mid-operation clears memory without waiting for clk.
- After rst_n deasserts, the first write can occur at the next rising edge.
- Reset values: out = 0, rw = 0. result and zero follow their inputs, e.g. result 0 / zero 1 for an unsupported opcode.

## Test plan
- ADD/SUB wrap: funct 100000 with in1 = 0xFFFFFFFF, in2 = 1 -> result 0, zero 1, rw 1. funct 100010 with in1 = 0, in2 = 1 -> result 0xFFFFFFFF, zero 0.
- Logic/shift: AND 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; OR -> 0xFFF0FFF0. SLL in2 = 1, shamt 31 -> 0x80000000. SRL in2 = 0x80000000, shamt 31 -> 1.
- Store/load: SW with wdata 0xDEADBEEF, address 8 -> out at address 8 shows 0 before the edge and 0xDEADBEEF after it. LW in1 = 4, in2 = 4 -> result 8, rw 1, out 0xDEADBEEF.
- Wrap/alignment: SW to address 0x100 with DEPTH 64 -> word 0 written. Reading address 3 returns word 0.
- BEQ/illegal: opcode 000100 with in1 = in2 = 7 -> zero 1, rw 0. opcode 111111 -> result 0, rw 0, and memory unchanged across an edge.
- Reset: fill words 0 and 5, then assert rst_n low between edges -> out reads 0 immediately. SW during reset is not written. After release, SW at the next edge succeeds.
